// File: rtl/serial_cmd_response_builder.sv
// Serialises one decoded command result into a framed response written byte by byte
// into the UART TX FIFO: START, STATUS, COUNT, [8 x PAYLOAD], CHECK, STOP.
module serial_cmd_response_builder #(
    parameter logic [7:0] START_BYTE = 8'hFF,
    parameter logic [7:0] STOP_BYTE  = 8'hEE,
    parameter logic [7:0] OK_CODE    = 8'h00,
    parameter logic [7:0] ERR_CODE   = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_processed,
    input  logic        cmd_decode_success,
    input  logic [7:0]  cmd_bytes_processed,
    input  logic [7:0]  cmd_payload_r0,
    input  logic [7:0]  cmd_payload_r1,
    input  logic [7:0]  cmd_payload_r2,
    input  logic [7:0]  cmd_payload_r3,
    input  logic [7:0]  cmd_payload_r4,
    input  logic [7:0]  cmd_payload_r5,
    input  logic [7:0]  cmd_payload_r6,
    input  logic [7:0]  cmd_payload_r7,
    output logic        cmd_processed_received,
    input  logic        tx_full,
    output logic        tx_push,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [15:0] frames_sent
);

    typedef enum logic [3:0] {
        IDLE, CAPTURE, START, STATUS, COUNT, PAYLOAD, CHECK, STOP, DONE
    } state_t;

    state_t     state;
    logic       succ_q;
    logic [7:0] count_q;
    logic [7:0] chk;
    logic [7:0] payload_q [8];
    logic [2:0] idx;
    logic [7:0] cur_byte;

    always_comb begin
        cur_byte = START_BYTE;
        case (state)
            STATUS:  cur_byte = succ_q ? OK_CODE : ERR_CODE;
            COUNT:   cur_byte = count_q;
            PAYLOAD: cur_byte = payload_q[idx];
            CHECK:   cur_byte = chk;
            STOP:    cur_byte = STOP_BYTE;
            default: cur_byte = START_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            succ_q                 <= 1'b0;
            count_q                <= '0;
            chk                    <= '0;
            idx                    <= '0;
            cmd_processed_received <= 1'b0;
            tx_push                <= 1'b0;
            tx_data                <= '0;
            busy                   <= 1'b0;
            frames_sent            <= '0;
            for (int unsigned i = 0; i < 8; i++) payload_q[i] <= '0;
        end else begin
            tx_push <= 1'b0;

            // Four-phase acknowledge runs independently of frame progress.
            if (state == CAPTURE)
                cmd_processed_received <= 1'b1;
            else if (cmd_processed_received && !cmd_processed)
                cmd_processed_received <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_processed && !cmd_processed_received)
                        state <= CAPTURE;
                end

                // START_BYTE goes out on the capture edge to reach two-cycle latency;
                // START is only visited when the FIFO is full at that moment.
                CAPTURE: begin
                    succ_q       <= cmd_decode_success;
                    count_q      <= cmd_bytes_processed;
                    payload_q[0] <= cmd_payload_r0;
                    payload_q[1] <= cmd_payload_r1;
                    payload_q[2] <= cmd_payload_r2;
                    payload_q[3] <= cmd_payload_r3;
                    payload_q[4] <= cmd_payload_r4;
                    payload_q[5] <= cmd_payload_r5;
                    payload_q[6] <= cmd_payload_r6;
                    payload_q[7] <= cmd_payload_r7;
                    busy         <= 1'b1;
                    chk          <= '0;
                    idx          <= '0;
                    if (!tx_full) begin
                        tx_push <= 1'b1;
                        tx_data <= START_BYTE;
                        state   <= STATUS;
                    end else begin
                        state   <= START;
                    end
                end

                START, STOP, CHECK: begin
                    if (!tx_full) begin
                        tx_push <= 1'b1;
                        tx_data <= cur_byte;
                        case (state)
                            START:   state <= STATUS;
                            CHECK:   state <= STOP;
                            default: state <= DONE;
                        endcase
                    end
                end

                STATUS, COUNT, PAYLOAD: begin
                    if (!tx_full) begin
                        tx_push <= 1'b1;
                        tx_data <= cur_byte;
                        chk     <= chk ^ cur_byte;
                        if (state == STATUS)
                            state <= COUNT;
                        else if (state == COUNT)
                            state <= succ_q ? PAYLOAD : CHECK;
                        else begin
                            idx <= idx + 3'd1;
                            if (idx == 3'd7)
                                state <= CHECK;
                        end
                    end
                end

                DONE: begin
                    frames_sent <= frames_sent + 16'd1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_response_builder.sv
// Scoreboard bench: stimulus queues the expected frame bytes, a negedge monitor pops
// and compares every pushed byte; directed cases plus randomized commands/backpressure.
module tb_serial_cmd_response_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_processed = 1'b0;
    logic        cmd_decode_success = 1'b0;
    logic [7:0]  cmd_bytes_processed = '0;
    logic [7:0]  pl_in [8];
    logic        cmd_processed_received;
    logic        tx_full;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    int  exp_frames = 0;
    bit  force_full = 1'b0;
    bit  bp_en = 1'b0;
    logic full_q = 1'b0;

    serial_cmd_response_builder #(
        .START_BYTE(8'hFF),
        .STOP_BYTE (8'hEE),
        .OK_CODE   (8'h00),
        .ERR_CODE  (8'h01)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_processed          (cmd_processed),
        .cmd_decode_success     (cmd_decode_success),
        .cmd_bytes_processed    (cmd_bytes_processed),
        .cmd_payload_r0         (pl_in[0]),
        .cmd_payload_r1         (pl_in[1]),
        .cmd_payload_r2         (pl_in[2]),
        .cmd_payload_r3         (pl_in[3]),
        .cmd_payload_r4         (pl_in[4]),
        .cmd_payload_r5         (pl_in[5]),
        .cmd_payload_r6         (pl_in[6]),
        .cmd_payload_r7         (pl_in[7]),
        .cmd_processed_received (cmd_processed_received),
        .tx_full                (tx_full),
        .tx_push                (tx_push),
        .tx_data                (tx_data),
        .busy                   (busy),
        .frames_sent            (frames_sent)
    );

    always #10 clk = ~clk;

    always @(posedge clk) full_q <= tx_full;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame built straight from the frame rules.
    function automatic int model_frame(input bit succ, input logic [7:0] cnt, input logic [63:0] pl);
        logic [7:0] st, c;
        int n;
        st = succ ? 8'h00 : 8'h01;
        c  = st ^ cnt;
        exp_q.push_back(8'hFF);
        exp_q.push_back(st);
        exp_q.push_back(cnt);
        n = 5;
        if (succ) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(pl[8*i +: 8]);
                c = c ^ pl[8*i +: 8];
            end
            n = 13;
        end
        exp_q.push_back(c);
        exp_q.push_back(8'hEE);
        return n;
    endfunction

    // Monitor: every push must match the next expected byte and never happen while full.
    initial begin
        forever begin
            @(negedge clk);
            if (full_q) cmp("push_while_full", tx_push, 1'b0);
            if (tx_push === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push: got %0h expected no push at %0t", tx_data, $time);
                end else begin
                    cmp("tx_data", tx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        tx_full = 1'b0;
        forever begin
            @(negedge clk);
            tx_full = force_full || (bp_en && ($urandom_range(0, 3) == 0));
        end
    end

    task automatic scramble_inputs();
        cmd_decode_success  = 1'($urandom);
        cmd_bytes_processed = 8'($urandom);
        for (int i = 0; i < 8; i++) pl_in[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs();
        cmp("rst_ack", cmd_processed_received, 1'b0);
        cmp("rst_push", tx_push, 1'b0);
        cmp("rst_data", tx_data, 8'h00);
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_frames", frames_sent, 16'h0000);
    endtask

    task automatic run_cmd(input bit succ, input logic [7:0] cnt, input logic [63:0] pl,
                           input int hold, input bit check_lat, input bit bp, input int stall_at);
        int waited = 0, n_push = 0, first = -1, last = -1, drop_at = -1, stall_left = 0, len;
        bit ack_seen = 0, stalled = 0, done = 0;
        @(negedge clk);
        cmd_decode_success  = succ;
        cmd_bytes_processed = cnt;
        for (int i = 0; i < 8; i++) pl_in[i] = pl[8*i +: 8];
        cmd_processed = 1'b1;
        bp_en = bp;
        len = model_frame(succ, cnt, pl);
        while (!done && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) force_full = 1'b0;
            end
            if (tx_push) begin
                if (first < 0) begin
                    first = waited;
                    if (check_lat) cmp("first_push_latency", first, 2);
                end
                last = waited;
                n_push++;
            end
            if (stall_at >= 0 && !stalled && n_push == stall_at) begin
                force_full = 1'b1;
                stall_left = 5;
                stalled = 1;
            end
            if (cmd_processed_received) ack_seen = 1;
            if (drop_at < 0 && ack_seen && waited >= hold) begin
                cmp("ack_held", cmd_processed_received, 1'b1);
                cmd_processed = 1'b0;
                scramble_inputs();
                drop_at = waited;
            end else if (drop_at >= 0 && waited == drop_at + 1) begin
                cmp("ack_release", cmd_processed_received, 1'b0);
            end
            if (drop_at >= 0 && waited > drop_at + 1 && !busy) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no completion expected frame done within 400 cycles");
        end
        force_full = 1'b0;
        cmp("frame_len", n_push, len);
        if (!bp) cmp("frame_span", last - first, len - 1 + (stalled ? 5 : 0));
        exp_frames = (exp_frames + 1) & 32'hFFFF;
        cmp("frames_sent", frames_sent, exp_frames);
        cmp("busy_after_done", busy, 1'b0);
        bp_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cmp("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n, w;
        for (int i = 0; i < 8; i++) pl_in[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (tx_push) n++;
        end
        cmp("idle_no_push", n, 0);

        run_cmd(1'b1, 8'h0B, 64'h0807060504030201, 3, 1'b1, 1'b0, -1);
        run_cmd(1'b0, 8'h04, 64'hA5A5_5A5A_1234_5678, 3, 1'b1, 1'b0, -1);
        run_cmd(1'b1, 8'h0B, 64'h0807060504030201, 3, 1'b0, 1'b0, 6);
        run_cmd(1'b1, 8'h21, 64'hDEAD_BEEF_0BAD_F00D, 40, 1'b0, 1'b0, -1);

        // Abort after the fourth byte; remaining bytes never leave the DUT.
        @(negedge clk);
        cmd_decode_success  = 1'b1;
        cmd_bytes_processed = 8'h0B;
        for (int i = 0; i < 8; i++) pl_in[i] = 8'(i + 1);
        cmd_processed = 1'b1;
        void'(model_frame(1'b1, 8'h0B, 64'h0807060504030201));
        n = 0;
        w = 0;
        while (n < 4 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
            if (tx_push) n++;
        end
        cmp("pushes_before_reset", n, 4);
        rst = 1'b1;
        cmd_processed = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_frames = 0;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        run_cmd(1'b1, 8'h0B, 64'h0807060504030201, 2, 1'b1, 1'b0, -1);

        for (int k = 0; k < 30; k++) begin
            run_cmd(1'($urandom), 8'($urandom), {$urandom, $urandom},
                    int'($urandom_range(1, 20)), 1'b0, 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_cmd_response_builder.md
Name: serial_cmd_response_builder

Overview:
Downstream neighbour of serial_cmd_decoder. Accepts one decoded command result per handshake: status, processed-byte count and the eight payload registers. Serialises a response frame byte by byte into the TX FIFO that feeds the UART transmitter. Gives the serial command processor its reply path to the host.

Parameters:
START_BYTE, 8'hFF, first byte of every response frame
STOP_BYTE, 8'hEE, last byte of every response frame
OK_CODE, 8'h00, status byte sent when decode succeeded
ERR_CODE, 8'h01, status byte sent when decode failed

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous active-high reset
cmd_processed  input  1  decoder result valid; held high until acknowledged
cmd_decode_success  input  1  1 = decode OK, 0 = decode error
cmd_bytes_processed  input  8  bytes consumed by decoder for this command
cmd_payload_r0..cmd_payload_r7  input  8 each  decoded payload registers
cmd_processed_received  output  1  acknowledge to decoder
tx_full  input  1  TX FIFO full
tx_push  output  1  TX FIFO push strobe, one byte per asserted cycle
tx_data  output  8  byte written when tx_push=1
busy  output  1  frame capture/transmission in progress
frames_sent  output  16  count of completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values: cmd_processed_received=0, tx_push=0, tx_data=8'h00, busy=0, frames_sent=0. State=IDLE. Internal latches cleared.
- Reset mid-frame: abort immediately. No further pushes. The partial frame already in the FIFO is not retracted. The acknowledge drops.
- States: IDLE, CAPTURE, START, STATUS, COUNT, PAYLOAD, CHECK, STOP, DONE.
- IDLE -> CAPTURE when cmd_processed=1 and cmd_processed_received=0.
- CAPTURE (1 cycle):
  - Latch success flag, count and r0..r7.
  - Set cmd_processed_received=1 and busy=1.
  - Initialise chk=0.
- Acknowledge is 4-phase:
  - cmd_processed_received stays high until a cycle where cmd_processed=0 is sampled; it then clears on the next edge.
  - This is independent of frame progress.
  - A new command is never latched while the acknowledge is high. This prevents re-latching the same result.
- Emit states push exactly one byte each, advancing only when tx_full=0.
- When tx_full=1: tx_push=0, stay in state, tx_data may hold. No byte is skipped or duplicated.
- tx_data is registered together with tx_push, so the byte appears in the same cycle as the strobe.
- Frame content:
  - START: START_BYTE.
  - STATUS: OK_CODE if the latched success flag is 1, else ERR_CODE.
  - COUNT: latched cmd_bytes_processed.
  - PAYLOAD: only on success; r0 first through r7, with a 3-bit index. On error, go COUNT -> CHECK directly.
  - CHECK: 8-bit XOR of STATUS, COUNT and all payload bytes sent. START and STOP are excluded.
  - STOP: STOP_BYTE.
- Frame length: success 13 bytes; error 5 bytes.
- Minimum latency:
  - cmd_processed rising -> first tx_push: 2 cycles (IDLE sample, CAPTURE).
  - Back-to-back pushes with no FIFO backpressure.
- DONE (1 cycle):
  - frames_sent += 1 (mod 2^16).
  - busy=0.
  - Return to IDLE.
- Back-to-back commands: the next command is accepted from IDLE only after the acknowledge has completed. If the decoder drops cmd_processed during the frame, the next command can be accepted on the cycle after DONE.
- Input changes after CAPTURE have no effect on the frame in flight.

Test Plan:
- Reset check: after reset, all outputs are zero; hold cmd_processed=0 for 20 cycles -> no tx_push.
- Success frame: success=1, count=8'h0B, r0..r7=8'h01..8'h08, tx_full=0, then drop cmd_processed after the ack.
  - Pushes FF,00,0B,01,02,03,04,05,06,07,08,03,EE on 13 consecutive cycles (chk = 00^0B^01^…^08 = 8'h03).
  - First push 2 cycles after request; frames_sent=1.
- Error frame: success=0, count=8'h04.
  - Pushes FF,01,04,05,EE (chk = 01^04 = 05).
  - Payload is not sent; busy low after DONE.
- Backpressure: assert tx_full for 5 cycles during PAYLOAD byte r3.
  - No push while full; the sequence resumes with r3 unchanged.
  - Total frame bytes still 13, identical to the unstalled case.
- Handshake hold: keep cmd_processed high for 40 cycles.
  - Exactly one frame is emitted; cmd_processed_received stays high until cmd_processed drops.
  - The acknowledge then clears 1 cycle later and no second frame is emitted.
- Reset mid-frame: assert rst after the 4th byte.
  - No further pushes; outputs return to reset values.
  - A subsequent command produces a complete frame.
